// File: rtl/audio_mixer.sv
// Fixed-rate registered audio mixer feeding audio_out: per-source attenuation,
// saturating sum with sticky clip flag, speaker idle suppression and a mute gain ramp.
module audio_mixer #(
  parameter int          CLOCK_SPEED_HZ       = 27_000_000,
  parameter int          SAMPLE_RATE          = 44100,
  parameter int          SPEAKER_IDLE_SAMPLES = 2048,
  parameter logic [15:0] SPEAKER_LEVEL        = 16'h2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ssp_audio_i,
  input  logic [9:0]  mb_audio_l_i,
  input  logic [9:0]  mb_audio_r_i,
  input  logic        speaker_i,
  input  logic        speaker_enable_i,
  input  logic [2:0]  ssp_shift_i,
  input  logic [2:0]  mb_shift_i,
  input  logic        mute_i,
  input  logic        clip_clear_i,
  output logic [15:0] audio_l_o,
  output logic [15:0] audio_r_o,
  output logic        sample_valid_o,
  output logic        clip_o
);

  // DIV must be at least 4 so consecutive samples never overlap in the pipeline.
  localparam int DIV    = CLOCK_SPEED_HZ / SAMPLE_RATE;
  localparam int CNT_W  = $clog2(DIV);
  localparam int IDLE_W = $clog2(SPEAKER_IDLE_SAMPLES + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(SPEAKER_IDLE_SAMPLES);
  localparam logic [8:0]        GAIN_UNITY = 9'd256;

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;

  assign tick = (tick_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  logic              speaker_prev;
  logic [IDLE_W-1:0] idle_cnt;
  logic              spk_edge;
  logic [15:0]       spk_term;

  assign spk_edge = speaker_i ^ speaker_prev;
  assign spk_term = (speaker_prev && speaker_enable_i && (idle_cnt < IDLE_LIMIT))
                    ? SPEAKER_LEVEL : 16'h0000;

  // A parked speaker line holds a DC offset; silence it once edges stop.
  always_ff @(posedge clk) begin
    if (reset) begin
      speaker_prev <= 1'b0;
      idle_cnt     <= IDLE_LIMIT;
    end else begin
      speaker_prev <= speaker_i;
      if (spk_edge)                          idle_cnt <= '0;
      else if (tick && idle_cnt < IDLE_LIMIT) idle_cnt <= idle_cnt + 1'b1;
    end
  end

  logic        s1_valid;
  logic [15:0] s1_ssp;
  logic [14:0] s1_mb_l;
  logic [14:0] s1_mb_r;
  logic [15:0] s1_spk;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_ssp   <= '0;
      s1_mb_l  <= '0;
      s1_mb_r  <= '0;
      s1_spk   <= '0;
    end else begin
      s1_valid <= tick;
      if (tick) begin
        s1_ssp  <= ssp_audio_i >> ssp_shift_i;
        s1_mb_l <= {mb_audio_l_i, 5'b0} >> mb_shift_i;
        s1_mb_r <= {mb_audio_r_i, 5'b0} >> mb_shift_i;
        s1_spk  <= spk_term;
      end
    end
  end

  logic [17:0] sum_l;
  logic [17:0] sum_r;
  logic        sat_l;
  logic        sat_r;

  assign sum_l = 18'(s1_ssp) + 18'(s1_mb_l) + 18'(s1_spk);
  assign sum_r = 18'(s1_ssp) + 18'(s1_mb_r) + 18'(s1_spk);
  assign sat_l = |sum_l[17:16];
  assign sat_r = |sum_r[17:16];

  logic        s2_valid;
  logic [15:0] s2_sum_l;
  logic [15:0] s2_sum_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_sum_l <= '0;
      s2_sum_r <= '0;
      clip_o   <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sum_l <= sat_l ? 16'hFFFF : sum_l[15:0];
        s2_sum_r <= sat_r ? 16'hFFFF : sum_r[15:0];
      end
      // A saturation in the same cycle as a clear must stay visible.
      if (s1_valid && (sat_l || sat_r)) clip_o <= 1'b1;
      else if (clip_clear_i)            clip_o <= 1'b0;
    end
  end

  logic [8:0] gain;

  always_ff @(posedge clk) begin
    if (reset) begin
      audio_l_o      <= '0;
      audio_r_o      <= '0;
      sample_valid_o <= 1'b0;
      gain           <= '0;
    end else begin
      sample_valid_o <= s2_valid;
      if (s2_valid) begin
        audio_l_o <= 16'((25'(s2_sum_l) * 25'(gain)) >> 8);
        audio_r_o <= 16'((25'(s2_sum_r) * 25'(gain)) >> 8);
        // One gain step per sample gives a click-free 256-sample ramp.
        if (mute_i && gain != 9'd0)              gain <= gain - 1'b1;
        else if (!mute_i && gain != GAIN_UNITY)  gain <= gain + 1'b1;
      end
    end
  end

endmodule

// File: doc/audio_mixer.md
Name: audio_mixer

Overview:
- Sample-rate mixer that sits directly upstream of audio_out.
- Replaces the free-running combinational sum of SuperSprite, Mockingboard and speaker audio with a registered mix at a fixed sample rate.
- Provides per-source attenuation, saturating summation, sticky clip detection and speaker DC-idle suppression.
- Provides a click-free mute/unmute gain ramp.
- Runs in the clk_pixel domain that feeds audio_out.

Parameters:
- CLOCK_SPEED_HZ, 27_000_000: frequency of clk.
- SAMPLE_RATE, 44100: output sample rate. DIV = CLOCK_SPEED_HZ/SAMPLE_RATE, floored (612 at defaults).
- SPEAKER_IDLE_SAMPLES, 2048: number of ticks without a speaker edge before the speaker contribution is forced to 0.
- SPEAKER_LEVEL, 16'h2000: speaker contribution when the effective speaker level is high.

Ports:
- clk  in  1  mixer clock (clk_pixel)
- reset  in  1  synchronous, active-high reset
- ssp_audio_i  in  16  SuperSprite audio, unsigned
- mb_audio_l_i  in  10  Mockingboard left, unsigned
- mb_audio_r_i  in  10  Mockingboard right, unsigned
- speaker_i  in  1  Apple speaker toggle level
- speaker_enable_i  in  1  0 forces speaker contribution to 0
- ssp_shift_i  in  3  right-shift attenuation on ssp (0..7)
- mb_shift_i  in  3  right-shift attenuation on the Mockingboard term (0..7)
- mute_i  in  1  1 ramps gain down to 0; 0 ramps gain up to unity
- clip_clear_i  in  1  clears clip_o
- audio_l_o  out  16  mixed left sample, unsigned
- audio_r_o  out  16  mixed right sample, unsigned
- sample_valid_o  out  1  one-cycle strobe when audio_*_o update
- clip_o  out  1  sticky: a saturation has occurred

Behaviour:
- Reset values:
  - audio_l_o = audio_r_o = 0; sample_valid_o = 0; clip_o = 0
  - tick counter = 0; gain g = 0
  - speaker idle counter = SPEAKER_IDLE_SAMPLES (speaker silent); registered speaker_prev = 0
  - pipeline registers = 0
- Tick generation:
  - Counter runs 0..DIV-1 and wraps to 0.
  - tick is asserted in the cycle where counter == DIV-1, so ticks are spaced exactly DIV clocks apart.
- Speaker edge detection and idle tracking:
  - speaker_prev registers speaker_i every clock; an edge is speaker_i != speaker_prev.
  - Any edge zeroes the idle counter.
  - Otherwise the idle counter increments on each tick, saturating at SPEAKER_IDLE_SAMPLES.
  - An edge and a tick in the same cycle: edge wins, counter = 0.
  - spk_term = SPEAKER_LEVEL when speaker_prev && speaker_enable_i && idle < SPEAKER_IDLE_SAMPLES; else 0.
- Stage 1 (cycle tick+1):
  - Capture ssp_term = ssp_audio_i >> ssp_shift_i.
  - Capture mbL = {mb_audio_l_i,5'b0} >> mb_shift_i; mbR likewise from mb_audio_r_i.
  - Capture spk_term.
  - Inputs are sampled only at tick; changes between ticks are ignored.
- Stage 2 (tick+2):
  - Compute 18-bit sums sumL = ssp_term + mbL + spk_term, and sumR likewise with mbR.
  - Each sum saturates to 16'hFFFF if it exceeds 16'hFFFF.
  - Any saturation sets clip_o.
  - clip_clear_i clears clip_o; a set in the same cycle wins.
- Stage 3 (tick+3):
  - audio_x_o = (sat_sum_x * g) >> 8, using a 25-bit product truncated to 16 bits. g = 256 is exact unity.
  - sample_valid_o = 1 for exactly this cycle.
  - After g is used for this output, it steps once:
    - mute_i = 1 and g > 0: g decrements by 1.
    - mute_i = 0 and g < 256: g increments by 1.
  - Full ramp is 256 samples (~5.8 ms).
  - Toggling mute_i mid-ramp reverses direction from the current g with no jump.
- Latency and overlap:
  - Fixed latency: 3 clocks from tick to sample_valid_o.
  - DIV >= 4 is required, so no pipeline overlap.
- Reset asserted mid-pipeline:
  - All stages clear.
  - The next valid sample appears 3 clocks after the first tick following release, with g = 0 (silent start, then ramp up).

Test Plan:
- Reset, then ssp=16'h1000, shifts=0, mb=0, mute=0 → valid pulses exactly 612 clocks apart, first valid 3 clocks after counter==611. Outputs in order: 0x0000 (g=0), 0x0010 (g=1), … ; from the 257th sample on, constant 0x1000.
- At unity, ssp=16'hFFFF, mb_l=10'h3FF, mb_r=0 → audio_l_o=0xFFFF, clip_o=1, audio_r_o=0xFFFF. Hold clip_clear_i=1 with inputs zeroed → clip_o=0. clip_clear_i=1 in the same cycle as a saturation → clip_o remains 1.
- Speaker: all other inputs 0, enable=1. Toggle speaker_i to 1, then hold → outputs 0x2000 for samples until idle reaches 2048, then 0x0000. Toggle again (to 0) then to 1 → 0x2000 resumes. With speaker_enable_i=0 → always 0.
- Attenuation: ssp=16'h8000, ssp_shift=3, mb_l=10'h200, mb_shift=1 → audio_l_o = 0x1000 + 0x2000 = 0x3000.
- Mute: at g=256 with ssp=16'h1000, assert mute_i → outputs decrease by 0x10 per sample. Deassert after 100 samples (g=156) → g increases from 156, no step larger than 0x10.
- Assert reset for one cycle mid-ramp (g=128) → the next cycle shows outputs 0 and clip_o 0. After release, the first valid output is 0x0000 and the ramp restarts from g=0.
